// File: rtl/ppu_hv_latch.sv
// ============================================================================
//  Module      : ppu_hv_latch
//  Description : PPU2 H/V counter latch. Freezes the live dot/line counters
//                into OPHCT/OPVCT on light-gun, WRIO or $2137 latch events
//                and serves the $2137/$213C/$213D/$213F CPU reads.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ppu_hv_latch #(
  parameter logic [3:0] PPU2_VER = 4'd3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [8:0] HCNT,
  input  logic [8:0] VCNT,
  input  logic       FIELD,
  input  logic       PAL,
  input  logic       EXTLATCH_N,
  input  logic       IO_EN,
  input  logic       RD_SLHV,
  input  logic       RD_OPHCT,
  input  logic       RD_OPVCT,
  input  logic       RD_STAT78,
  input  logic [7:0] OPEN_BUS,
  output logic [7:0] DO,
  output logic       LATCHED
);

  // Synchronizer chain; s3 is the previous s2 used for fall detection.
  logic       s1_q, s2_q, s3_q;
  logic       io_en_q;
  logic [8:0] ophct_q, ophct_d;
  logic [8:0] opvct_q, opvct_d;
  logic       latched_q, latched_d;
  logic       hsel_q, hsel_d;
  logic       vsel_q, vsel_d;
  logic [7:0] do_q, do_d;

  // One-hot read strobes resolved by fixed priority STAT78 > OPHCT > OPVCT > SLHV.
  logic rd_stat, rd_h, rd_v, rd_slhv;
  logic ext_ev, io_fall_ev, latch_ev;

  assign rd_stat = RD_STAT78;
  assign rd_h    = RD_OPHCT & ~RD_STAT78;
  assign rd_v    = RD_OPVCT & ~RD_STAT78 & ~RD_OPHCT;
  assign rd_slhv = RD_SLHV  & ~RD_STAT78 & ~RD_OPHCT & ~RD_OPVCT;

  // All latch sources collapse into a single event per cycle.
  assign ext_ev     = s3_q & ~s2_q & IO_EN;
  assign io_fall_ev = io_en_q & ~IO_EN;
  assign latch_ev   = ext_ev | io_fall_ev | (rd_slhv & IO_EN);

  // Next-state: latch capture, flag set/clear, byte selects and read data.
  always_comb begin
    ophct_d   = ophct_q;
    opvct_d   = opvct_q;
    latched_d = latched_q;
    hsel_d    = hsel_q;
    vsel_d    = vsel_q;
    do_d      = do_q;

    if (rd_stat) begin
      // DO reflects the pre-cycle flag; a simultaneous latch re-sets it below.
      do_d      = {FIELD, latched_q, OPEN_BUS[5], PAL, PPU2_VER};
      latched_d = 1'b0;
      hsel_d    = 1'b0;
      vsel_d    = 1'b0;
    end else if (rd_h) begin
      do_d   = hsel_q ? {OPEN_BUS[7:1], ophct_q[8]} : ophct_q[7:0];
      hsel_d = ~hsel_q;
    end else if (rd_v) begin
      do_d   = vsel_q ? {OPEN_BUS[7:1], opvct_q[8]} : opvct_q[7:0];
      vsel_d = ~vsel_q;
    end else if (rd_slhv) begin
      do_d = OPEN_BUS;
    end

    if (latch_ev) begin
      ophct_d   = HCNT;
      opvct_d   = VCNT;
      latched_d = 1'b1;
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      io_en_q   <= 1'b1;
      ophct_q   <= 9'd0;
      opvct_q   <= 9'd0;
      latched_q <= 1'b0;
      hsel_q    <= 1'b0;
      vsel_q    <= 1'b0;
      do_q      <= 8'h00;
    end else begin
      s1_q      <= EXTLATCH_N;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      io_en_q   <= IO_EN;
      ophct_q   <= ophct_d;
      opvct_q   <= opvct_d;
      latched_q <= latched_d;
      hsel_q    <= hsel_d;
      vsel_q    <= vsel_d;
      do_q      <= do_d;
    end
  end

  assign DO      = do_q;
  assign LATCHED = latched_q;

endmodule

`default_nettype wire

// File: tb/tb_ppu_hv_latch.sv
// ============================================================================
//  Module      : tb_ppu_hv_latch
//  Description : Directed self-checking bench for ppu_hv_latch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ppu_hv_latch;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [8:0] HCNT, VCNT;
  logic       FIELD, PAL, EXTLATCH_N, IO_EN;
  logic       RD_SLHV, RD_OPHCT, RD_OPVCT, RD_STAT78;
  logic [7:0] OPEN_BUS;
  logic [7:0] DO;
  logic       LATCHED;

  int tests = 0;
  int fails = 0;

  ppu_hv_latch #(.PPU2_VER(4'd3)) dut (
    .CLK(CLK), .RESET(RESET), .HCNT(HCNT), .VCNT(VCNT), .FIELD(FIELD),
    .PAL(PAL), .EXTLATCH_N(EXTLATCH_N), .IO_EN(IO_EN), .RD_SLHV(RD_SLHV),
    .RD_OPHCT(RD_OPHCT), .RD_OPVCT(RD_OPVCT), .RD_STAT78(RD_STAT78),
    .OPEN_BUS(OPEN_BUS), .DO(DO), .LATCHED(LATCHED)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0=$2137 1=$213C 2=$213D 3=$213F
  task automatic rd(input int kind, output logic [7:0] d);
    RD_SLHV   = (kind == 0);
    RD_OPHCT  = (kind == 1);
    RD_OPVCT  = (kind == 2);
    RD_STAT78 = (kind == 3);
    tick();
    RD_SLHV = 0; RD_OPHCT = 0; RD_OPVCT = 0; RD_STAT78 = 0;
    d = DO;
  endtask

  logic [7:0] d;

  initial begin
    RESET = 1; HCNT = 0; VCNT = 0; FIELD = 1; PAL = 0; EXTLATCH_N = 1; IO_EN = 1;
    RD_SLHV = 0; RD_OPHCT = 0; RD_OPVCT = 0; RD_STAT78 = 0; OPEN_BUS = 8'h5C;
    tick(); tick(); tick();
    RESET = 0;

    // Reset state
    chk("rst_do", DO, 8'h00);
    chk("rst_latched", {7'd0, LATCHED}, 8'h00);
    rd(1, d); chk("rst_ophct", d, 8'h00);
    rd(3, d); chk("rst_stat", d, 8'h83);

    // External latch: fall in cycle N, sampled in N+2
    HCNT = 9'h011; EXTLATCH_N = 0; tick();
    HCNT = 9'h022; tick();
    HCNT = 9'h123; VCNT = 9'h0A5;
    chk("ext_pre_latched", {7'd0, LATCHED}, 8'h00);
    tick();
    HCNT = 9'h044; VCNT = 9'h000;
    chk("ext_latched", {7'd0, LATCHED}, 8'h01);
    rd(1, d); chk("ext_h_lo", d, 8'h23);
    rd(1, d); chk("ext_h_hi", d, 8'h5D);
    rd(2, d); chk("ext_v_lo", d, 8'hA5);
    rd(2, d); chk("ext_v_hi", d, 8'h5C);
    rd(3, d); chk("ext_stat1", d, 8'hC3);
    rd(3, d); chk("ext_stat2", d, 8'h83);
    EXTLATCH_N = 1; tick(); tick(); tick();

    // EXTLATCH_N held low 100 cycles: one latch at HCNT of fall cycle + 2
    for (int i = 0; i < 100; i++) begin
      HCNT = 9'h100 + 9'(i);
      EXTLATCH_N = 0;
      tick();
    end
    rd(1, d); chk("hold_h_lo", d, 8'h02);
    rd(1, d); chk("hold_h_hi", d, 8'h5D);
    rd(3, d); chk("hold_stat", d, 8'hC3);
    EXTLATCH_N = 1; tick(); tick(); tick();

    // IO_EN fall latches; then IO_EN=0 blocks external and $2137 latches
    HCNT = 9'h0AB; IO_EN = 0; tick();
    chk("iofall_latched", {7'd0, LATCHED}, 8'h01);
    rd(3, d); chk("iofall_stat", d, 8'hC3);
    HCNT = 9'h077;
    EXTLATCH_N = 0; tick(); tick(); tick();
    EXTLATCH_N = 1; tick(); tick(); tick();
    EXTLATCH_N = 0; tick();
    EXTLATCH_N = 1; tick(); tick(); tick();
    rd(0, d); chk("slhv_openbus", d, 8'h5C);
    rd(1, d); chk("dis_h_lo", d, 8'hAB);
    rd(3, d); chk("dis_stat", d, 8'h83);
    IO_EN = 1; tick();
    HCNT = 9'd200; IO_EN = 0; tick();
    HCNT = 9'd5;
    rd(1, d); chk("io200_h_lo", d, 8'hC8);
    rd(1, d); chk("io200_h_hi", d, 8'h5C);
    rd(3, d); chk("io200_stat", d, 8'hC3);

    // STAT78 clears hsel
    rd(1, d); chk("hsel_first", d, 8'hC8);
    rd(3, d); chk("hsel_stat", d, 8'h83);
    rd(1, d); chk("hsel_cleared", d, 8'hC8);
    rd(3, d);

    // Latch and STAT78 in the same cycle
    IO_EN = 1; tick();
    HCNT = 9'h1EE; IO_EN = 0; RD_STAT78 = 1; tick();
    RD_STAT78 = 0;
    chk("coll_stat_do", DO, 8'h83);
    chk("coll_stat_latched", {7'd0, LATCHED}, 8'h01);

    // Latch and RD_OPHCT in the same cycle: old byte now, new value next read
    IO_EN = 1; tick();
    HCNT = 9'h033; IO_EN = 0; RD_OPHCT = 1; tick();
    RD_OPHCT = 0;
    chk("coll_h_old", DO, 8'hEE);
    rd(1, d); chk("coll_h_new_hi", d, 8'h5C);

    // Priority: STAT78 beats OPHCT, hsel untouched apart from STAT78 clear
    RD_OPHCT = 1; RD_STAT78 = 1; tick();
    RD_OPHCT = 0; RD_STAT78 = 0;
    chk("prio_stat", DO, 8'hC3);
    rd(1, d); chk("prio_h_lo", d, 8'h33);

    // Reset mid-sequence after a latch and one RD_OPHCT
    IO_EN = 1; tick();
    HCNT = 9'h0F0; EXTLATCH_N = 0; tick(); tick(); tick();
    rd(1, d);
    HCNT = 0; VCNT = 0;
    RESET = 1; tick(); RESET = 0;
    chk("rst2_do", DO, 8'h00);
    chk("rst2_latched", {7'd0, LATCHED}, 8'h00);
    rd(1, d); chk("rst2_h_lo", d, 8'h00);
    rd(1, d); chk("rst2_h_hi", d, 8'h5C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ppu_hv_latch.md
# ppu_hv_latch

PPU2-side H/V counter latch that consumes the light-gun port's active-low latch line (controller pin 6 / IOBit) and CPU latch requests. It freezes the live dot/line counters into OPHCT/OPVCT and serves the $2137, $213C, $213D and $213F register reads to the CPU bus. It sits between the controller-port devices and the CPU B-bus read mux.

## Interface
Parameters:
- PPU2_VER, 4'd3: version returned in STAT78[3:0]

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- HCNT  in  9  live PPU dot counter (0..339), valid every CLK
- VCNT  in  9  live PPU line counter (0..261 NTSC / 0..311 PAL)
- FIELD  in  1  current interlace field
- PAL  in  1  1 = PAL timing
- EXTLATCH_N  in  1  asynchronous latch line from controller port 2 pin 6, active low
- IO_EN  in  1  level of $4201 bit 7 (WRIO), held by CPU-side logic
- RD_SLHV  in  1  one-CLK strobe: CPU read of $2137
- RD_OPHCT  in  1  one-CLK strobe: CPU read of $213C
- RD_OPVCT  in  1  one-CLK strobe: CPU read of $213D
- RD_STAT78  in  1  one-CLK strobe: CPU read of $213F
- OPEN_BUS  in  8  PPU2 open-bus byte, used for undriven bits
- DO  out  8  read data
- LATCHED  out  1  STAT78 bit 6 counter-latch flag, exported for debug

## Operation
- EXTLATCH_N passes through a 2-flop synchronizer (s1, s2) reset to 1. An external latch event is s2 falling 1->0 while IO_EN=1.
- An IO_EN falling edge, detected against a registered copy reset to 1, is also a latch event.
- RD_SLHV is a latch event when IO_EN=1. The read itself returns OPEN_BUS.
- Latch event actions:
  - OPHCT <= HCNT and OPVCT <= VCNT, both sampled on the event cycle.
  - LATCHED <= 1.
  - Multiple events in one cycle produce a single latch.
- Byte selection uses two independent flip-flops, hsel and vsel.
  - RD_OPHCT: hsel=0 returns OPHCT[7:0]. hsel=1 returns {OPEN_BUS[7:1], OPHCT[8]}. Then hsel toggles.
  - RD_OPVCT behaves the same way with vsel and OPVCT.
- RD_STAT78 returns {FIELD, LATCHED, OPEN_BUS[5], PAL, PPU2_VER}. It then clears LATCHED, hsel and vsel.
- Read strobes are one-hot by contract. If several are asserted, priority is STAT78 > OPHCT > OPVCT > SLHV, and only the winner updates state.
- A latch event and a RD_STAT78 in the same cycle:
  - DO shows the pre-cycle LATCHED.
  - The set wins, so LATCHED ends at 1. hsel and vsel still clear.
- A latch event and an RD_OPHCT/RD_OPVCT in the same cycle: DO returns the old OPHCT/OPVCT byte, and the new value is visible from the next read.
- Counter values are stored raw with no range check or wrap adjustment.

## Timing
- Reset values: OPHCT=0, OPVCT=0, LATCHED=0, hsel=0, vsel=0, DO=8'h00, synchronizer and IO_EN copy =1. A latch in progress is discarded.
- External latency: an EXTLATCH_N fall in cycle N is detected as an event in cycle N+2, and HCNT/VCNT are sampled in N+2.
- OPHCT, OPVCT and LATCHED update at the end of the event cycle.
- DO is registered and valid the cycle after a strobe. It holds its value until the next strobe.
- No strobe requires handshake or back-pressure. Every strobe completes in one cycle.
- EXTLATCH_N held low generates one event only. A new event needs a return to 1, and glitches under 2 CLK may be missed.

## Test plan
- IO_EN=1, EXTLATCH_N pulsed low, HCNT=9'h123 and VCNT=9'h0A5 on the detection cycle -> reads of $213C,$213C,$213D,$213D return 8'h23, {OPEN_BUS[7:1],1}, 8'hA5, {OPEN_BUS[7:1],0}; $213F bit6=1, then 0 on a second read.
- IO_EN=0 with EXTLATCH_N toggling, plus an RD_SLHV -> OPHCT/OPVCT unchanged and LATCHED stays 0; then IO_EN 1->0 with HCNT=9'd200 -> OPHCT=200 and LATCHED=1.
- RD_OPHCT once (hsel=1), then RD_STAT78, then RD_OPHCT -> the last read returns the low byte.
- Latch event and RD_STAT78 in the same cycle, with LATCHED=0 before -> DO bit6=0, and LATCHED=1 afterwards.
- EXTLATCH_N held low 100 cycles, HCNT incrementing -> exactly one latch, value equals HCNT at the fall cycle +2.
- RESET asserted mid-sequence after a latch and one RD_OPHCT -> all state returns to reset values, and the next RD_OPHCT returns 8'h00.
